// File: rtl/nap_time_setter.sv
// nap_time_setter
//   Front-end controller for the nap countdown. The user enters an HH:MM:SS
//   duration as six BCD digits with buttons, then runs it. While running, an
//   internal prescaler issues one start request per second to the countdown
//   stage. The decremented digits that stage returns are captured, and an
//   alarm is raised once it reports that all digits are zero.
//
// Ports
//   clock                 system clock, rising edge
//   reset                 asynchronous, active-low reset
//   btnSelect/btnUp/btnDown/btnStart/btnClear
//                         debounced button levels; only rising edges act
//   get*                  decremented BCD digits from the countdown stage
//   complete              countdown stage result valid (sampled only in WAIT)
//   isZero                countdown stage found all digits zero
//   set*                  held BCD digits (registered)
//   start                 one-cycle request to the countdown stage (registered)
//   cursor                digit under edit, 0=Second1 .. 5=Hour10
//   running               high in RUN or WAIT
//   alarm                 high in DONE
//   debugState            current FSM state (EDIT=0 RUN=1 WAIT=2 PAUSE=3 DONE=4)
//
// Handshake with the countdown stage: start is a single-cycle request; the
// stage answers later with complete held high for at least one cycle while
// the controller is in WAIT. No new request is issued until that answer
// has been taken.
module nap_time_setter #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnSelect,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnStart,
  input  logic       btnClear,
  input  logic [3:0] getHour10,
  input  logic [3:0] getHour1,
  input  logic [3:0] getMinute10,
  input  logic [3:0] getMinute1,
  input  logic [3:0] getSecond10,
  input  logic [3:0] getSecond1,
  input  logic       complete,
  input  logic       isZero,
  output logic [3:0] setHour10,
  output logic [3:0] setHour1,
  output logic [3:0] setMinute10,
  output logic [3:0] setMinute1,
  output logic [3:0] setSecond10,
  output logic [3:0] setSecond1,
  output logic       start,
  output logic [2:0] cursor,
  output logic       running,
  output logic       alarm,
  output logic [2:0] debugState
);

  typedef enum logic [2:0] {
    ST_EDIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } stateT;

  stateT             state, stateNext;
  // digits[0] = Second1 ... digits[5] = Hour10, matching cursor numbering
  logic [5:0][3:0]   digits, digitsNext;
  logic [2:0]        cursorNext;
  logic [CNT_W-1:0]  prescaler, prescalerNext;
  logic              startNext;

  // Button order in these vectors: {clear, start, select, up, down}
  logic [4:0] btnNow, btnPrev, btnEdge;
  logic       evClear, evStart, evSelect, evUp, evDown, anyEvent;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  // Minute10 and Second10 stop at 5; every other digit at 9.
  function automatic logic [3:0] digitMax(input logic [2:0] idx);
    return (idx == 3'd1 || idx == 3'd3) ? 4'd5 : 4'd9;
  endfunction

  assign btnNow  = {btnClear, btnStart, btnSelect, btnUp, btnDown};
  assign btnEdge = btnNow & ~btnPrev;

  // Fixed priority Clear > Start > Select > Up > Down; losers are dropped.
  assign evClear  = btnEdge[4];
  assign evStart  = btnEdge[3] & ~btnEdge[4];
  assign evSelect = btnEdge[2] & ~(|btnEdge[4:3]);
  assign evUp     = btnEdge[1] & ~(|btnEdge[4:2]);
  assign evDown   = btnEdge[0] & ~(|btnEdge[4:1]);
  assign anyEvent = |btnEdge;

  always_comb begin
    stateNext     = state;
    digitsNext    = digits;
    cursorNext    = cursor;
    prescalerNext = prescaler;
    startNext     = 1'b0;

    case (state)
      ST_EDIT: begin
        if (evClear) begin
          digitsNext = '0;
          cursorNext = 3'd0;
        end else if (evStart) begin
          if (digits != '0) begin
            prescalerNext = '0;
            stateNext     = ST_RUN;
          end
        end else if (evSelect) begin
          cursorNext = (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
        end else if (evUp) begin
          digitsNext[cursor] = (digits[cursor] >= digitMax(cursor)) ? 4'd0
                                                                     : digits[cursor] + 4'd1;
        end else if (evDown) begin
          digitsNext[cursor] = (digits[cursor] == 4'd0) ? digitMax(cursor)
                                                         : digits[cursor] - 4'd1;
        end
      end

      ST_RUN: begin
        if (evClear) begin
          digitsNext    = '0;
          cursorNext    = 3'd0;
          prescalerNext = '0;
          stateNext     = ST_EDIT;
        end else if (evStart) begin
          // Prescaler is left untouched so RUN resumes mid-second.
          stateNext = ST_PAUSE;
        end else if (prescaler == TICK_LAST) begin
          prescalerNext = '0;
          startNext     = 1'b1;
          stateNext     = ST_WAIT;
        end else begin
          prescalerNext = prescaler + 1'b1;
        end
      end

      ST_WAIT: begin
        if (evClear) begin
          digitsNext    = '0;
          cursorNext    = 3'd0;
          prescalerNext = '0;
          stateNext     = ST_EDIT;
        end else if (complete) begin
          if (isZero) begin
            stateNext = ST_DONE;
          end else begin
            digitsNext = {getHour10, getHour1, getMinute10,
                          getMinute1, getSecond10, getSecond1};
            stateNext  = ST_RUN;
          end
        end
      end

      ST_PAUSE: begin
        if (evClear) begin
          digitsNext    = '0;
          cursorNext    = 3'd0;
          prescalerNext = '0;
          stateNext     = ST_EDIT;
        end else if (evStart) begin
          stateNext = ST_RUN;
        end
      end

      ST_DONE: begin
        // Any press only acknowledges the alarm; it does not edit.
        if (anyEvent) begin
          digitsNext    = '0;
          cursorNext    = 3'd0;
          prescalerNext = '0;
          stateNext     = ST_EDIT;
        end
      end

      default: begin
        digitsNext    = '0;
        cursorNext    = 3'd0;
        prescalerNext = '0;
        stateNext     = ST_EDIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_EDIT;
      digits    <= '0;
      cursor    <= 3'd0;
      prescaler <= '0;
      start     <= 1'b0;
      btnPrev   <= '0;
    end else begin
      state     <= stateNext;
      digits    <= digitsNext;
      cursor    <= cursorNext;
      prescaler <= prescalerNext;
      start     <= startNext;
      btnPrev   <= btnNow;
    end
  end

  assign setSecond1  = digits[0];
  assign setSecond10 = digits[1];
  assign setMinute1  = digits[2];
  assign setMinute10 = digits[3];
  assign setHour1    = digits[4];
  assign setHour10   = digits[5];

  assign running    = (state == ST_RUN) || (state == ST_WAIT);
  assign alarm      = (state == ST_DONE);
  assign debugState = state;

endmodule

// File: tb/tb_nap_time_setter.sv
module tb_nap_time_setter;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  localparam logic [2:0] S_EDIT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clock;
  logic       reset;
  logic       btnSelect, btnUp, btnDown, btnStart, btnClear;
  logic [3:0] getHour10, getHour1, getMinute10, getMinute1, getSecond10, getSecond1;
  logic       complete, isZero;
  logic [3:0] setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1;
  logic       start;
  logic [2:0] cursor;
  logic       running, alarm;
  logic [2:0] debugState;

  int assertions = 0;
  int failures   = 0;

  nap_time_setter #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .btnSelect(btnSelect), .btnUp(btnUp), .btnDown(btnDown),
    .btnStart(btnStart), .btnClear(btnClear),
    .getHour10(getHour10), .getHour1(getHour1),
    .getMinute10(getMinute10), .getMinute1(getMinute1),
    .getSecond10(getSecond10), .getSecond1(getSecond1),
    .complete(complete), .isZero(isZero),
    .setHour10(setHour10), .setHour1(setHour1),
    .setMinute10(setMinute10), .setMinute1(setMinute1),
    .setSecond10(setSecond10), .setSecond1(setSecond1),
    .start(start), .cursor(cursor), .running(running), .alarm(alarm),
    .debugState(debugState)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] shownDigits();
    return {setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1};
  endfunction

  // ---------------- driver tasks ----------------
  // which: 0=select 1=up 2=down 3=start 4=clear
  task automatic press(input int which);
    case (which)
      0: btnSelect = 1'b1;
      1: btnUp     = 1'b1;
      2: btnDown   = 1'b1;
      3: btnStart  = 1'b1;
      default: btnClear = 1'b1;
    endcase
    tick();
    btnSelect = 1'b0; btnUp = 1'b0; btnDown = 1'b0; btnStart = 1'b0; btnClear = 1'b0;
    tick();
  endtask

  // Counts edges until start is seen high; returns limit+1 when it never comes.
  task automatic wait_start(input int limit, output int n);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_get(input logic [23:0] v);
    {getHour10, getHour1, getMinute10, getMinute1, getSecond10, getSecond1} = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    assertions++; if (shownDigits() !== 24'h0) begin failures++; $display("FAIL reset_digits: got %h want %h", shownDigits(), 24'h0); end
    assertions++; if (cursor !== 3'd0) begin failures++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    assertions++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start); end
    assertions++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running: got %b want 0", running); end
    assertions++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    assertions++; if (debugState !== S_EDIT) begin failures++; $display("FAIL reset_state: got %0d want %0d", debugState, S_EDIT); end
  endtask

  task automatic test_edit_wrap();
    press(0);
    assertions++; if (cursor !== 3'd1) begin failures++; $display("FAIL wrap_select: got %0d want 1", cursor); end
    press(2);
    assertions++; if (setSecond10 !== 4'd5) begin failures++; $display("FAIL wrap_down: got %0d want 5", setSecond10); end
    assertions++; if (shownDigits() !== 24'h000050) begin failures++; $display("FAIL wrap_only_cursor_digit: got %h want %h", shownDigits(), 24'h000050); end
    press(1);
    assertions++; if (setSecond10 !== 4'd0) begin failures++; $display("FAIL wrap_up: got %0d want 0", setSecond10); end
    repeat (5) press(0);
    assertions++; if (cursor !== 3'd0) begin failures++; $display("FAIL wrap_cursor: got %0d want 0", cursor); end
    // Select and Up on the same edge: Select wins, no digit change.
    btnSelect = 1'b1; btnUp = 1'b1;
    tick();
    btnSelect = 1'b0; btnUp = 1'b0;
    tick();
    assertions++; if (cursor !== 3'd1 || shownDigits() !== 24'h0) begin failures++; $display("FAIL select_over_up: got cursor %0d digits %h want cursor 1 digits 000000", cursor, shownDigits()); end
    repeat (5) press(0);
  endtask

  task automatic test_run_capture();
    int n;
    press(1); press(1);
    assertions++; if (shownDigits() !== 24'h000002) begin failures++; $display("FAIL setup_2s: got %h want 000002", shownDigits()); end
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    assertions++; if (running !== 1'b1 || debugState !== S_RUN) begin failures++; $display("FAIL run_entry: got running %b state %0d want 1/%0d", running, debugState, S_RUN); end
    wait_start(20, n);
    assertions++; if (n !== TICK_DIV) begin failures++; $display("FAIL start_latency: got %0d want %0d", n, TICK_DIV); end
    assertions++; if (debugState !== S_WAIT) begin failures++; $display("FAIL wait_entry: got %0d want %0d", debugState, S_WAIT); end
    set_get(24'h000001); complete = 1'b1; isZero = 1'b0;
    tick();
    complete = 1'b0;
    assertions++; if (shownDigits() !== 24'h000001) begin failures++; $display("FAIL capture_digits: got %h want 000001", shownDigits()); end
    assertions++; if (debugState !== S_RUN || start !== 1'b0) begin failures++; $display("FAIL capture_state: got state %0d start %b want %0d/0", debugState, start, S_RUN); end
  endtask

  task automatic test_expiry();
    int n;
    wait_start(20, n);
    assertions++; if (n !== TICK_DIV) begin failures++; $display("FAIL second_tick_latency: got %0d want %0d", n, TICK_DIV); end
    set_get(24'h000000); complete = 1'b1; isZero = 1'b1;
    tick();
    complete = 1'b0; isZero = 1'b0;
    assertions++; if (alarm !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL expiry_flags: got alarm %b running %b want 1/0", alarm, running); end
    assertions++; if (shownDigits() !== 24'h000001) begin failures++; $display("FAIL expiry_digits_held: got %h want 000001", shownDigits()); end
    btnUp = 1'b1;
    tick();
    btnUp = 1'b0;
    assertions++; if (alarm !== 1'b0 || debugState !== S_EDIT) begin failures++; $display("FAIL done_exit: got alarm %b state %0d want 0/%0d", alarm, debugState, S_EDIT); end
    assertions++; if (shownDigits() !== 24'h000000) begin failures++; $display("FAIL done_exit_digits: got %h want 000000", shownDigits()); end
    tick();
  endtask

  task automatic test_pause();
    int n;
    int pulses;
    press(1);
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    tick(); tick();          // prescaler now 2
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    assertions++; if (debugState !== S_PAUSE || running !== 1'b0) begin failures++; $display("FAIL pause_entry: got state %0d running %b want %0d/0", debugState, running, S_PAUSE); end
    pulses = 0;
    repeat (20) begin
      tick();
      if (start === 1'b1) pulses++;
    end
    assertions++; if (pulses !== 0) begin failures++; $display("FAIL pause_no_pulse: got %0d pulses want 0", pulses); end
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    wait_start(20, n);
    assertions++; if (n !== 2) begin failures++; $display("FAIL resume_latency: got %0d want 2", n); end
    // Clear outranks a simultaneous complete in WAIT.
    set_get(24'h999999); complete = 1'b1; isZero = 1'b0; btnClear = 1'b1;
    tick();
    complete = 1'b0; btnClear = 1'b0;
    assertions++; if (debugState !== S_EDIT || shownDigits() !== 24'h0) begin failures++; $display("FAIL wait_clear: got state %0d digits %h want %0d/000000", debugState, shownDigits(), S_EDIT); end
    tick();
  endtask

  task automatic test_priority();
    int pulses;
    repeat (4) press(0);
    press(1);
    assertions++; if (shownDigits() !== 24'h010000) begin failures++; $display("FAIL setup_1h: got %h want 010000", shownDigits()); end
    btnStart = 1'b1; btnClear = 1'b1;
    tick();
    btnStart = 1'b0; btnClear = 1'b0;
    tick();
    assertions++; if (debugState !== S_EDIT || shownDigits() !== 24'h0 || cursor !== 3'd0) begin failures++; $display("FAIL clear_over_start: got state %0d digits %h cursor %0d want %0d/000000/0", debugState, shownDigits(), cursor, S_EDIT); end
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    assertions++; if (debugState !== S_EDIT || running !== 1'b0) begin failures++; $display("FAIL zero_start_ignored: got state %0d running %b want %0d/0", debugState, running, S_EDIT); end
    pulses = 0;
    repeat (10) begin
      tick();
      if (start === 1'b1) pulses++;
    end
    assertions++; if (pulses !== 0) begin failures++; $display("FAIL zero_start_no_pulse: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_async_reset();
    int n;
    int pulses;
    press(1);
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    wait_start(20, n);
    assertions++; if (debugState !== S_WAIT) begin failures++; $display("FAIL pre_reset_wait: got %0d want %0d", debugState, S_WAIT); end
    #2;
    reset = 1'b0;
    #1;
    assertions++; if (shownDigits() !== 24'h0 || start !== 1'b0) begin failures++; $display("FAIL async_outputs: got digits %h start %b want 000000/0", shownDigits(), start); end
    assertions++; if (debugState !== S_EDIT || running !== 1'b0) begin failures++; $display("FAIL async_state: got state %0d running %b want %0d/0", debugState, running, S_EDIT); end
    tick();
    reset = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (start === 1'b1) pulses++;
    end
    assertions++; if (pulses !== 0 || debugState !== S_EDIT) begin failures++; $display("FAIL post_reset_quiet: got %0d pulses state %0d want 0/%0d", pulses, debugState, S_EDIT); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    btnSelect = 1'b0; btnUp = 1'b0; btnDown = 1'b0; btnStart = 1'b0; btnClear = 1'b0;
    complete = 1'b0; isZero = 1'b0;
    set_get(24'h0);
    reset = 1'b0;
    test_reset();
    test_edit_wrap();
    test_run_capture();
    test_expiry();
    test_pause();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
